// File: rtl/sync_cnter_mod.sv
// ---------------------------------------------------------------------------
// sync_cnter_mod
//   Parametrised synchronous modulo-MODULUS up/down counter. Every flop is
//   clocked by clk_i, so there is no ripple skew between bits. Instances can
//   be chained by feeding one digit's tc_o into the next digit's en_i.
//
// Parameters
//   WIDTH    counter width in bits (>= 1)
//   MODULUS  count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   RST_VAL  value forced while reset is asserted (< MODULUS)
//
// Ports
//   clk_i   counter clock, rising edge
//   rst_i   asynchronous reset, active-low
//   clr_i   synchronous clear to 0             (highest priority)
//   ld_i    synchronous load of d_i, clamped to MODULUS-1
//   d_i     load value
//   en_i    count enable / cascade input       (lowest priority)
//   dir_i   1 = count up, 0 = count down
//   sat_i   1 = stop at the terminal value, 0 = wrap around
//   cnt_o   registered count
//   tc_o    combinational terminal count, drives the next digit's en_i
//   wrap_o  registered one-cycle pulse following each wrap
// ---------------------------------------------------------------------------
module sync_cnter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int RST_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             wrap_o
);

  // Terminal value truncated to WIDTH so MODULUS = 2**WIDTH gives all-ones
  // and the wrap becomes the natural binary rollover.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero, term;

  assign at_max  = (cnt_q == MAX_VAL);
  assign at_zero = (cnt_q == '0);
  assign term    = dir_i ? at_max : at_zero;

  // Next-state: clr > ld > en > hold. Increments only happen below MAX_VAL
  // and decrements only above zero, so no intermediate exceeds WIDTH bits.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = (d_i > MAX_VAL) ? MAX_VAL : d_i;
    end else if (en_i) begin
      if (dir_i) begin
        if (!at_max) begin
          cnt_d = cnt_q + ONE;
        end else if (!sat_i) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          cnt_d = cnt_q - ONE;
        end else if (!sat_i) begin
          cnt_d  = MAX_VAL;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= RST_CNT;
      wrap_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;
  // Gated by rst_i: while held in reset the count may sit at a terminal value,
  // but the cascade must stay quiet.
  assign tc_o   = rst_i & en_i & ~clr_i & ~ld_i & term;

endmodule

// File: tb/tb_sync_cnter_mod.sv
// ---------------------------------------------------------------------------
// tb_sync_cnter_mod
//   Four counters share clk/rst_n:
//     0: WIDTH=4 MODULUS=10 RST_VAL=0  (main unit)
//     1: WIDTH=4 MODULUS=16 RST_VAL=3  (full-range rollover)
//     2: MODULUS=10 low digit of a cascade
//     3: MODULUS=10 high digit, en_i driven by digit 2's tc_o
//   The driver applies inputs on the falling edge, advances an integer
//   reference model, and queues the expected tc_o (pre-edge) and cnt/wrap
//   (post-edge). Two monitor processes pop and compare independently.
// ---------------------------------------------------------------------------
module tb_sync_cnter_mod;

  typedef struct packed {
    logic [3:0][3:0] cnt;
    logic [3:0]      wrap;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       clr_r [4];
  logic       ld_r  [4];
  logic [3:0] d_r   [4];
  logic       en_r  [4];
  logic       dir_r [4];
  logic       sat_r [4];
  logic [3:0] cnt_w [4];
  logic       tc_w  [4];
  logic       wrap_w[4];

  // staged stimulus, copied onto the DUT inputs at the next falling edge
  bit         s_clr [4];
  bit         s_ld  [4];
  int         s_d   [4];
  bit         s_en  [4];
  bit         s_dir [4];
  bit         s_sat [4];

  int         mcnt  [4];
  exp_t       st_q[$];
  logic [3:0] tc_q[$];

  int vectors = 0;
  int errors  = 0;

  sync_cnter_mod #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_a (
    .clk_i(clk), .rst_i(rst_n), .clr_i(clr_r[0]), .ld_i(ld_r[0]), .d_i(d_r[0]),
    .en_i(en_r[0]), .dir_i(dir_r[0]), .sat_i(sat_r[0]),
    .cnt_o(cnt_w[0]), .tc_o(tc_w[0]), .wrap_o(wrap_w[0]));

  sync_cnter_mod #(.WIDTH(4), .MODULUS(16), .RST_VAL(3)) u_b (
    .clk_i(clk), .rst_i(rst_n), .clr_i(clr_r[1]), .ld_i(ld_r[1]), .d_i(d_r[1]),
    .en_i(en_r[1]), .dir_i(dir_r[1]), .sat_i(sat_r[1]),
    .cnt_o(cnt_w[1]), .tc_o(tc_w[1]), .wrap_o(wrap_w[1]));

  sync_cnter_mod #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_lo (
    .clk_i(clk), .rst_i(rst_n), .clr_i(clr_r[2]), .ld_i(ld_r[2]), .d_i(d_r[2]),
    .en_i(en_r[2]), .dir_i(dir_r[2]), .sat_i(sat_r[2]),
    .cnt_o(cnt_w[2]), .tc_o(tc_w[2]), .wrap_o(wrap_w[2]));

  sync_cnter_mod #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_hi (
    .clk_i(clk), .rst_i(rst_n), .clr_i(clr_r[3]), .ld_i(ld_r[3]), .d_i(d_r[3]),
    .en_i(tc_w[2]), .dir_i(dir_r[3]), .sat_i(sat_r[3]),
    .cnt_o(cnt_w[3]), .tc_o(tc_w[3]), .wrap_o(wrap_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int mod_of(input int i);
    return (i == 1) ? 16 : 10;
  endfunction

  function automatic int rst_of(input int i);
    return (i == 1) ? 3 : 0;
  endfunction

  task automatic check(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: behaviour of one edge in plain integer arithmetic.
  function automatic void model_next(input int m, input int c, input bit clr,
                                     input bit ld, input int d, input bit en,
                                     input bit dir, input bit sat,
                                     output int nc, output bit nw);
    int t;
    nc = c;
    nw = 1'b0;
    if (clr) begin
      nc = 0;
    end else if (ld) begin
      nc = (d < m) ? d : m - 1;
    end else if (en) begin
      t = dir ? c + 1 : c - 1;
      if (t >= 0 && t < m) nc = t;
      else if (!sat) begin
        nc = (t + m) % m;
        nw = 1'b1;
      end
    end
  endfunction

  task automatic step();
    exp_t       e;
    logic [3:0] tcx;
    bit         en_m;
    int         nc;
    bit         nw;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      clr_r[i] = s_clr[i];
      ld_r[i]  = s_ld[i];
      d_r[i]   = 4'(s_d[i]);
      en_r[i]  = s_en[i];
      dir_r[i] = s_dir[i];
      sat_r[i] = s_sat[i];
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      en_m   = (i == 3) ? tcx[2] : s_en[i];
      tcx[i] = en_m && !s_clr[i] && !s_ld[i] &&
               (s_dir[i] ? (mcnt[i] == mod_of(i) - 1) : (mcnt[i] == 0));
      model_next(mod_of(i), mcnt[i], s_clr[i], s_ld[i], s_d[i], en_m,
                 s_dir[i], s_sat[i], nc, nw);
      mcnt[i]   = nc;
      e.cnt[i]  = 4'(nc);
      e.wrap[i] = nw;
    end
    tc_q.push_back(tcx);
    st_q.push_back(e);
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      s_clr[i] = 0; s_ld[i] = 0; s_d[i] = 0;
      s_en[i]  = 0; s_dir[i] = 1; s_sat[i] = 0;
    end
  endtask

  task automatic reset_checks();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_cnt%0d", i), int'(cnt_w[i]), rst_of(i));
      check($sformatf("rst_wrap%0d", i), int'(wrap_w[i]), 0);
      check($sformatf("rst_tc%0d", i), int'(tc_w[i]), 0);
    end
  endtask

  // monitor: registered outputs, just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          check($sformatf("cnt%0d", i), int'(cnt_w[i]), int'(e.cnt[i]));
          check($sformatf("wrap%0d", i), int'(wrap_w[i]), int'(e.wrap[i]));
        end
      end
    end
  end

  // monitor: combinational tc_o, after inputs settle and before the edge
  initial begin
    logic [3:0] t;
    forever begin
      @(negedge clk);
      #2;
      if (tc_q.size() > 0) begin
        t = tc_q.pop_front();
        for (int i = 0; i < 4; i++)
          check($sformatf("tc%0d", i), int'(tc_w[i]), int'(t[i]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // enabled, counting down at RST_VAL=0: term is true, tc must stay gated
      clr_r[i] = 0; ld_r[i] = 0; d_r[i] = '0;
      en_r[i]  = 1; dir_r[i] = 0; sat_r[i] = 0;
      mcnt[i]  = rst_of(i);
    end
    idle_all();
    #12;
    reset_checks();
    @(posedge clk); #3; rst_n = 1'b1;

    // count unit 0 to 5, then reset asynchronously mid-cycle
    s_en[0] = 1;
    repeat (5) step();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    reset_checks();
    for (int i = 0; i < 4; i++) mcnt[i] = rst_of(i);
    @(posedge clk); #3; rst_n = 1'b1;

    // up-wrap on unit 0, 25-edge cascade, full-range rollover on unit 1
    s_en[0] = 1; s_en[2] = 1;
    for (int k = 0; k < 25; k++) begin
      s_ld[1] = (k == 0); s_d[1] = 15;
      s_en[1] = (k == 1 || k == 2);
      s_dir[1] = (k != 2);
      step();
    end
    idle_all();
    @(posedge clk); #2;
    check("cascade_lo", int'(cnt_w[2]), 5);
    check("cascade_hi", int'(cnt_w[3]), 2);

    // down-saturate from a loaded 2
    s_ld[0] = 1; s_d[0] = 2;
    step();
    s_ld[0] = 0; s_en[0] = 1; s_dir[0] = 0; s_sat[0] = 1;
    repeat (4) step();

    // priority and clamp
    idle_all();
    s_clr[0] = 1; s_ld[0] = 1; s_d[0] = 7;
    step();
    s_clr[0] = 0; s_d[0] = 13; s_en[0] = 1;
    step();
    s_d[0] = 4; s_en[0] = 0;
    step();

    // randomized traffic on all units
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        s_clr[i] = ($urandom_range(0, 19) == 0);
        s_ld[i]  = ($urandom_range(0, 9) == 0);
        s_d[i]   = int'($urandom_range(0, 15));
        s_en[i]  = ($urandom_range(0, 3) != 0);
        s_dir[i] = ($urandom_range(0, 5) != 0) ? s_dir[i] : !s_dir[i];
        s_sat[i] = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    idle_all();
    repeat (2) step();
    @(posedge clk); #3;
    check("st_q_drained", st_q.size(), 0);
    check("tc_q_drained", tc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
